// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, position type and sync-level helper.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam logic VGA_SYNC_POL = 1'b0;

    localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef logic [POS_W-1:0] pos_t;

    // Map an internal "sync asserted" flag to the pin level for a given polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return pol ? active : ~active;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster outputs from the timing generator to the pattern generator / pins.
interface vga_timing_if;
    import vga_timing_pkg::*;

    pos_t hpos;
    pos_t vpos;
    logic visible;
    logic hsync;
    logic vsync;
    logic frame_strobe;

    modport master (output hpos, vpos, visible, hsync, vsync, frame_strobe);
    modport slave  (input  hpos, vpos, visible, hsync, vsync, frame_strobe);

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (H or V). Holds the position register and
// decodes wrap/active/sync from the value the register is about to take, so the
// parent can register flags that line up with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    output pos_t count,
    output logic wrap,
    output logic active,
    output logic sync_active
);

    localparam int   TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam pos_t LAST       = pos_t'(TOTAL - 1);
    localparam pos_t VIS_END    = pos_t'(VISIBLE);
    localparam pos_t SYNC_START = pos_t'(VISIBLE + FRONT);
    localparam pos_t SYNC_END   = pos_t'(VISIBLE + FRONT + SYNC);

    pos_t count_nxt;

    // Next-position and flag decode; wrap only counts when actually advancing.
    always_comb begin
        wrap      = advance && (count == LAST);
        count_nxt = count;
        if (advance) begin
            count_nxt = wrap ? '0 : count + pos_t'(1);
        end
        active      = (count_nxt < VIS_END);
        sync_active = (count_nxt >= SYNC_START) && (count_nxt < SYNC_END);
    end

    // Position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_nxt;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source (counters, visible, syncs, frame strobe).
// Optional build macro VGA_TIMING_SYNC_DELAY_EN: add one flop to hsync/vsync so they
// line up with the pattern generator's registered video.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic SYNC_POL  = VGA_SYNC_POL
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    vga_timing_if.master tim
);

    pos_t h_count, v_count;
    logic h_wrap, h_active, h_sync;
    logic v_wrap, v_active, v_sync;
    logic v_advance;

    logic visible_q, hsync_q, vsync_q, strobe_q;

    assign v_advance = i_enable && h_wrap;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk(i_clk), .rst_n(i_rst_n), .advance(i_enable),
        .count(h_count), .wrap(h_wrap), .active(h_active), .sync_active(h_sync)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk(i_clk), .rst_n(i_rst_n), .advance(v_advance),
        .count(v_count), .wrap(v_wrap), .active(v_active), .sync_active(v_sync)
    );

    // Flags follow the counters only while enabled, so the reset-time (0,0)
    // stays invisible until the first advance and a freeze holds everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            visible_q <= 1'b0;
            hsync_q   <= sync_level(1'b0, SYNC_POL);
            vsync_q   <= sync_level(1'b0, SYNC_POL);
            strobe_q  <= 1'b0;
        end else begin
            strobe_q <= v_wrap;
            if (i_enable) begin
                visible_q <= h_active && v_active;
                hsync_q   <= sync_level(h_sync, SYNC_POL);
                vsync_q   <= sync_level(v_sync, SYNC_POL);
            end
        end
    end

`ifdef VGA_TIMING_SYNC_DELAY_EN
    logic hsync_d, vsync_d;

    // One extra stage on the syncs only; runs every clock so it settles during a freeze.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hsync_d <= sync_level(1'b0, SYNC_POL);
            vsync_d <= sync_level(1'b0, SYNC_POL);
        end else begin
            hsync_d <= hsync_q;
            vsync_d <= vsync_q;
        end
    end

    assign tim.hsync = hsync_d;
    assign tim.vsync = vsync_d;
`else
    assign tim.hsync = hsync_q;
    assign tim.vsync = vsync_q;
`endif

    assign tim.hpos         = h_count;
    assign tim.vpos         = v_count;
    assign tim.visible      = visible_q;
    assign tim.frame_strobe = strobe_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench. DUT A uses the 640x480 defaults (first lines),
// DUT B a shrunken raster (100x60) so full frames fit in a short run.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    localparam int SYNC_LAT = 1;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic rst_n;
    logic en;

    vga_timing_if ifa ();
    vga_timing_if ifb ();

    vga_timing_gen dut_a (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .tim(ifa));

    vga_timing_gen #(
        .H_VISIBLE(64), .H_FRONT(8), .H_SYNC(16), .H_BACK(12),
        .V_VISIBLE(48), .V_FRONT(3), .V_SYNC(2),  .V_BACK(7),
        .SYNC_POL(1'b0)
    ) dut_b (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .tim(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pos_t oh[2], ov[2];
    logic ovis[2], ohs[2], ovs[2], ost[2];
    assign oh[0] = ifa.hpos;         assign oh[1] = ifb.hpos;
    assign ov[0] = ifa.vpos;         assign ov[1] = ifb.vpos;
    assign ovis[0] = ifa.visible;    assign ovis[1] = ifb.visible;
    assign ohs[0] = ifa.hsync;       assign ohs[1] = ifb.hsync;
    assign ovs[0] = ifa.vsync;       assign ovs[1] = ifb.vsync;
    assign ost[0] = ifa.frame_strobe; assign ost[1] = ifb.frame_strobe;

    typedef struct {
        int dut;
        int h;
        int v;
        bit vis;
        bit hs;
        bit vs;
        bit st;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // raster geometry per DUT
    int hv[2] = '{640, 64};
    int hf[2] = '{16, 8};
    int hw[2] = '{96, 16};
    int hb[2] = '{48, 12};
    int vv[2] = '{480, 48};
    int vf[2] = '{10, 3};
    int vw[2] = '{2, 2};
    int vb[2] = '{33, 7};

    // reference raster state
    int mh[2], mv[2];
    bit mvis[2], mhs[2], mvs[2], mst[2], mhs_d[2], mvs_d[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mh[d] = 0; mv[d] = 0; mvis[d] = 0; mst[d] = 0;
            mhs[d] = 1; mvs[d] = 1; mhs_d[d] = 1; mvs_d[d] = 1;
        end
    endtask

    task automatic model_step(input bit e_in);
        for (int d = 0; d < 2; d++) begin
            int ht, vt;
            ht = hv[d] + hf[d] + hw[d] + hb[d];
            vt = vv[d] + vf[d] + vw[d] + vb[d];
            mhs_d[d] = mhs[d];
            mvs_d[d] = mvs[d];
            if (e_in) begin
                mst[d] = (mh[d] == ht - 1) && (mv[d] == vt - 1);
                if (mh[d] == ht - 1) begin
                    mh[d] = 0;
                    mv[d] = (mv[d] == vt - 1) ? 0 : mv[d] + 1;
                end else begin
                    mh[d] = mh[d] + 1;
                end
                mvis[d] = (mh[d] < hv[d]) && (mv[d] < vv[d]);
                mhs[d]  = !((mh[d] >= hv[d] + hf[d]) && (mh[d] < hv[d] + hf[d] + hw[d]));
                mvs[d]  = !((mv[d] >= vv[d] + vf[d]) && (mv[d] < vv[d] + vf[d] + vw[d]));
            end else begin
                mst[d] = 0;
            end
        end
    endtask

    // One clock: drive enable at negedge, push expectations, return #1 after posedge.
    task automatic step(input bit e_in);
        exp_t x;
        @(negedge clk);
        en = e_in;
        model_step(e_in);
        for (int d = 0; d < 2; d++) begin
            x.dut = d; x.h = mh[d]; x.v = mv[d]; x.vis = mvis[d]; x.st = mst[d];
            x.hs = (SYNC_LAT != 0) ? mhs_d[d] : mhs[d];
            x.vs = (SYNC_LAT != 0) ? mvs_d[d] : mvs[d];
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop every expectation pushed for this edge and compare.
    always @(posedge clk) begin
        exp_t e;
        int d;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d = e.dut;
            n_checks += 6;
            if (oh[d] !== pos_t'(e.h)) begin
                n_errors++; $display("FAIL sb_hpos dut%0d: got %0d expected %0d", d, oh[d], e.h);
            end
            if (ov[d] !== pos_t'(e.v)) begin
                n_errors++; $display("FAIL sb_vpos dut%0d: got %0d expected %0d", d, ov[d], e.v);
            end
            if (ovis[d] !== e.vis) begin
                n_errors++; $display("FAIL sb_visible dut%0d at (%0d,%0d): got %b expected %b", d, e.h, e.v, ovis[d], e.vis);
            end
            if (ohs[d] !== e.hs) begin
                n_errors++; $display("FAIL sb_hsync dut%0d at (%0d,%0d): got %b expected %b", d, e.h, e.v, ohs[d], e.hs);
            end
            if (ovs[d] !== e.vs) begin
                n_errors++; $display("FAIL sb_vsync dut%0d at (%0d,%0d): got %b expected %b", d, e.h, e.v, ovs[d], e.vs);
            end
            if (ost[d] !== e.st) begin
                n_errors++; $display("FAIL sb_strobe dut%0d at (%0d,%0d): got %b expected %b", d, e.h, e.v, ost[d], e.st);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (oh[d] !== '0 || ov[d] !== '0 || ovis[d] !== 1'b0 || ost[d] !== 1'b0 ||
                ohs[d] !== 1'b1 || ovs[d] !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: got h=%0d v=%0d vis=%b hs=%b vs=%b st=%b, expected 0 0 0 1 1 0",
                         d, oh[d], ov[d], ovis[d], ohs[d], ovs[d], ost[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (oh[d] !== pos_t'(1) || ov[d] !== '0 || ovis[d] !== 1'b1 || ost[d] !== 1'b0) begin
                n_errors++;
                $display("FAIL first_cycle dut%0d: got h=%0d v=%0d vis=%b st=%b, expected 1 0 1 0",
                         d, oh[d], ov[d], ovis[d], ost[d]);
            end
        end
    endtask

    task automatic test_line0();
        int hs_cnt = 0;
        int hs_first = -1;
        int hs_last = -1;
        int vis_cnt = 0;
        for (int i = 0; i < 799; i++) begin
            step(1'b1);
            if (ov[0] == '0) begin
                if (ovis[0] === 1'b1) vis_cnt++;
                if (ohs[0] === 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(oh[0]);
                    hs_last = int'(oh[0]);
                end
            end
        end
        n_checks += 3;
        if (hs_first != 656 + SYNC_LAT || hs_last != 751 + SYNC_LAT) begin
            n_errors++;
            $display("FAIL line0_hsync_window: got %0d..%0d expected %0d..%0d",
                     hs_first, hs_last, 656 + SYNC_LAT, 751 + SYNC_LAT);
        end
        if (hs_cnt != 96) begin
            n_errors++; $display("FAIL line0_hsync_width: got %0d expected 96", hs_cnt);
        end
        if (vis_cnt != 638) begin
            n_errors++; $display("FAIL line0_visible_count (hpos 2..799): got %0d expected 638", vis_cnt);
        end
    endtask

    task automatic test_line_wrap();
        for (int i = 0; i < 5000 && !(mh[0] == 799 && mv[0] == 4); i++) step(1'b1);
        n_checks++;
        if (!(mh[0] == 799 && mv[0] == 4)) begin
            n_errors++; $display("FAIL line_wrap_reach: stuck at (%0d,%0d) expected (799,4)", mh[0], mv[0]);
        end else begin
            step(1'b1);
            if (oh[0] !== '0 || ov[0] !== pos_t'(5) || ost[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL line_wrap: got h=%0d v=%0d st=%b expected 0 5 0", oh[0], ov[0], ost[0]);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int vs_lines = 0;
        int vs_first = -1;
        for (int i = 0; i < 7000 && !(mh[1] == 99 && mv[1] == 59); i++) begin
            step(1'b1);
            if (oh[1] == pos_t'(1) && ovs[1] === 1'b0) begin
                vs_lines++;
                if (vs_first < 0) vs_first = int'(ov[1]);
            end
        end
        n_checks += 3;
        if (vs_lines != 2 || vs_first != 51) begin
            n_errors++;
            $display("FAIL frame_vsync_lines: got %0d lines from %0d expected 2 from 51", vs_lines, vs_first);
        end
        if (!(mh[1] == 99 && mv[1] == 59)) begin
            n_errors++; $display("FAIL frame_wrap_reach: stuck at (%0d,%0d) expected (99,59)", mh[1], mv[1]);
        end else begin
            step(1'b1);
            if (oh[1] !== '0 || ov[1] !== '0 || ost[1] !== 1'b1) begin
                n_errors++;
                $display("FAIL frame_wrap: got h=%0d v=%0d st=%b expected 0 0 1", oh[1], ov[1], ost[1]);
            end
            step(1'b1);
            if (ost[1] !== 1'b0) begin
                n_errors++; $display("FAIL strobe_width: got %b expected 0", ost[1]);
            end
        end
    endtask

    task automatic test_freeze();
        pos_t a_h;
        for (int i = 0; i < 7000 && !(mh[1] == 30 && mv[1] == 10); i++) step(1'b1);
        a_h = oh[0];
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            n_checks++;
            if (oh[1] !== pos_t'(30) || ov[1] !== pos_t'(10) || ost[1] !== 1'b0 || oh[0] !== a_h) begin
                n_errors++;
                $display("FAIL freeze: got B=(%0d,%0d) st=%b A.h=%0d expected (30,10) 0 %0d",
                         oh[1], ov[1], ost[1], oh[0], a_h);
            end
        end
        step(1'b1);
        n_checks++;
        if (oh[1] !== pos_t'(31) || ov[1] !== pos_t'(10)) begin
            n_errors++; $display("FAIL resume: got (%0d,%0d) expected (31,10)", oh[1], ov[1]);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7000 && !(mh[1] == 50 && mv[1] == 20); i++) step(1'b1);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (oh[d] !== '0 || ov[d] !== '0 || ovis[d] !== 1'b0 || ost[d] !== 1'b0 ||
                ohs[d] !== 1'b1 || ovs[d] !== 1'b1) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: got h=%0d v=%0d vis=%b hs=%b vs=%b st=%b",
                         d, oh[d], ov[d], ovis[d], ohs[d], ovs[d], ost[d]);
            end
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        n_checks++;
        if (oh[1] !== pos_t'(1) || ov[1] !== '0 || ovis[1] !== 1'b1 || ost[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_restart: got h=%0d v=%0d vis=%b st=%b expected 1 0 1 0",
                     oh[1], ov[1], ovis[1], ost[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0);
    endtask

    initial begin
        test_reset();
        test_line0();
        test_line_wrap();
        test_frame_wrap();
        test_freeze();
        test_async_reset();
        test_back_to_back();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
